// File: rtl/psd_cdiv_pkg.sv
// Shared definitions for the complex-divider operand sequencer.
//   WIDTH_DEF       default signed operand width
//   state_t         sequencer FSM encoding (also driven out for debug)
//   S_RR..S_DI2     step indices of the six multiplications
//   acc_op_t        accumulate operation applied to a product
//   acc_tgt_t       which accumulator a step updates
//   step_op/step_tgt  step-table decode helpers
package psd_cdiv_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_ACC     = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

  localparam logic [2:0] S_RR  = 3'd0; // nr*dr
  localparam logic [2:0] S_II  = 3'd1; // ni*di
  localparam logic [2:0] S_IR  = 3'd2; // ni*dr
  localparam logic [2:0] S_RI  = 3'd3; // nr*di
  localparam logic [2:0] S_DR2 = 3'd4; // dr*dr
  localparam logic [2:0] S_DI2 = 3'd5; // di*di

  typedef enum logic [1:0] {
    ACC_LOAD = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_op_t;

  typedef enum logic [1:0] {
    TGT_RE  = 2'd0,
    TGT_IM  = 2'd1,
    TGT_MAG = 2'd2
  } acc_tgt_t;

  function automatic acc_op_t step_op(input logic [2:0] step);
    acc_op_t op;
    case (step)
      S_RR, S_IR, S_DR2: op = ACC_LOAD;
      S_II, S_DI2:       op = ACC_ADD;
      S_RI:              op = ACC_SUB;
      default:           op = ACC_LOAD;
    endcase
    return op;
  endfunction

  function automatic acc_tgt_t step_tgt(input logic [2:0] step);
    acc_tgt_t tgt;
    case (step)
      S_RR, S_II:   tgt = TGT_RE;
      S_IR, S_RI:   tgt = TGT_IM;
      S_DR2, S_DI2: tgt = TGT_MAG;
      default:      tgt = TGT_RE;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/cdiv_cmul_seq.sv
// Operand sequencer for the complex divider. Issues six products through an
// external sequential multiplier and accumulates
//   re_num = nr*dr + ni*di, im_num = ni*dr - nr*di, mag = dr^2 + di^2.
// Ports:
//   clock, reset (async, active-low)
//   start (pulse, IDLE only), busy, done (one-cycle pulse, results valid)
//   nr, ni, dr, di       signed operands, sampled on accepted start
//   re_num, im_num       signed PW+1 results; mag unsigned PW; dz = (mag==0)
//   mult_run, mult_busy, mult_a, mult_b, mult_p   multiplier interface
//   dbg_state            current FSM state
//
// Multiplier handshake: mult_run is a one-cycle strobe with mult_a/mult_b
// valid in that cycle and held until the product is consumed. The multiplier
// raises mult_busy (possibly already in the cycle after the strobe) and drops
// it when done; mult_p is valid from the first cycle busy is low and is
// sampled one cycle later, in ACC.
module cdiv_cmul_seq
  import psd_cdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PW    = 2 * WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic signed [WIDTH-1:0] nr,
  input  logic signed [WIDTH-1:0] ni,
  input  logic signed [WIDTH-1:0] dr,
  input  logic signed [WIDTH-1:0] di,
  output logic signed [PW:0]      re_num,
  output logic signed [PW:0]      im_num,
  output logic        [PW-1:0]    mag,
  output logic                    dz,
  output logic                    mult_run,
  input  logic                    mult_busy,
  output logic signed [WIDTH-1:0] mult_a,
  output logic signed [WIDTH-1:0] mult_b,
  input  logic signed [PW-1:0]    mult_p,
  output state_t                  dbg_state
);

  state_t                  state_q, state_d;
  logic [2:0]              step_q, step_d;
  logic signed [WIDTH-1:0] nr_q, nr_d, ni_q, ni_d, dr_q, dr_d, di_q, di_d;
  logic signed [PW:0]      re_acc_q, re_acc_d, im_acc_q, im_acc_d;
  logic        [PW-1:0]    mag_acc_q, mag_acc_d;
  logic                    busy_q, busy_d, done_q, done_d, run_q, run_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic signed [PW:0]      re_num_q, re_num_d, im_num_q, im_num_d;
  logic        [PW-1:0]    mag_q, mag_d;
  logic                    dz_q, dz_d;

  // Operand source: live inputs when launching step 0 from IDLE (the latches
  // are being loaded in that same cycle), otherwise the latched copies.
  logic [2:0]              op_step;
  logic signed [WIDTH-1:0] src_nr, src_ni, src_dr, src_di;
  logic signed [WIDTH-1:0] sel_a, sel_b;

  always_comb begin
    if (state_q == ST_IDLE) begin
      op_step = S_RR;
      src_nr  = nr;
      src_ni  = ni;
      src_dr  = dr;
      src_di  = di;
    end else begin
      op_step = 3'(step_q + 3'd1);
      src_nr  = nr_q;
      src_ni  = ni_q;
      src_dr  = dr_q;
      src_di  = di_q;
    end
    case (op_step)
      S_RR:    begin sel_a = src_nr; sel_b = src_dr; end
      S_II:    begin sel_a = src_ni; sel_b = src_di; end
      S_IR:    begin sel_a = src_ni; sel_b = src_dr; end
      S_RI:    begin sel_a = src_nr; sel_b = src_di; end
      S_DR2:   begin sel_a = src_dr; sel_b = src_dr; end
      S_DI2:   begin sel_a = src_di; sel_b = src_di; end
      default: begin sel_a = '0;     sel_b = '0;     end
    endcase
  end

  // Accumulator update for the step currently in ACC.
  logic signed [PW:0]   p_ext;
  logic signed [PW:0]   re_n, im_n;
  logic        [PW-1:0] mag_n;
  acc_op_t              cur_op;
  acc_tgt_t             cur_tgt;

  always_comb begin
    p_ext   = {mult_p[PW-1], mult_p};
    cur_op  = step_op(step_q);
    cur_tgt = step_tgt(step_q);
    re_n    = re_acc_q;
    im_n    = im_acc_q;
    mag_n   = mag_acc_q;
    case (cur_tgt)
      TGT_RE: begin
        case (cur_op)
          ACC_ADD: re_n = re_acc_q + p_ext;
          ACC_SUB: re_n = re_acc_q - p_ext;
          default: re_n = p_ext;
        endcase
      end
      TGT_IM: begin
        case (cur_op)
          ACC_ADD: im_n = im_acc_q + p_ext;
          ACC_SUB: im_n = im_acc_q - p_ext;
          default: im_n = p_ext;
        endcase
      end
      default: begin
        // Squares are never negative, so the product reads as unsigned.
        case (cur_op)
          ACC_ADD: mag_n = mag_acc_q + $unsigned(mult_p);
          default: mag_n = $unsigned(mult_p);
        endcase
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    nr_d      = nr_q;
    ni_d      = ni_q;
    dr_d      = dr_q;
    di_d      = di_q;
    re_acc_d  = re_acc_q;
    im_acc_d  = im_acc_q;
    mag_acc_d = mag_acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    run_d     = 1'b0;
    a_d       = a_q;
    b_d       = b_q;
    re_num_d  = re_num_q;
    im_num_d  = im_num_q;
    mag_d     = mag_q;
    dz_d      = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nr_d      = nr;
          ni_d      = ni;
          dr_d      = dr;
          di_d      = di;
          step_d    = S_RR;
          re_acc_d  = '0;
          im_acc_d  = '0;
          mag_acc_d = '0;
          busy_d    = 1'b1;
          run_d     = 1'b1;
          a_d       = sel_a;
          b_d       = sel_b;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (mult_busy)  state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (!mult_busy) state_d = ST_ACC;
      ST_ACC: begin
        re_acc_d  = re_n;
        im_acc_d  = im_n;
        mag_acc_d = mag_n;
        if (step_q == S_DI2) begin
          // Results and done land together in the FIN cycle.
          re_num_d = re_n;
          im_num_d = im_n;
          mag_d    = mag_n;
          dz_d     = (mag_n == '0);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_FIN;
        end else begin
          step_d  = 3'(step_q + 3'd1);
          run_d   = 1'b1;
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = ST_ISSUE;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      nr_q      <= '0;
      ni_q      <= '0;
      dr_q      <= '0;
      di_q      <= '0;
      re_acc_q  <= '0;
      im_acc_q  <= '0;
      mag_acc_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      run_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      re_num_q  <= '0;
      im_num_q  <= '0;
      mag_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      nr_q      <= nr_d;
      ni_q      <= ni_d;
      dr_q      <= dr_d;
      di_q      <= di_d;
      re_acc_q  <= re_acc_d;
      im_acc_q  <= im_acc_d;
      mag_acc_q <= mag_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      run_q     <= run_d;
      a_q       <= a_d;
      b_q       <= b_d;
      re_num_q  <= re_num_d;
      im_num_q  <= im_num_d;
      mag_q     <= mag_d;
      dz_q      <= dz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mult_run  = run_q;
  assign mult_a    = a_q;
  assign mult_b    = b_q;
  assign re_num    = re_num_q;
  assign im_num    = im_num_q;
  assign mag       = mag_q;
  assign dz        = dz_q;
  assign dbg_state = state_q;

endmodule
